// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_event_ctrl
// Brief    : Synchronises, debounces and turns N push-buttons into one-cycle
//            press / release / auto-repeat events on a shared sample tick.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_ctrl #(
  parameter int N_BTN       = 4,
  parameter int TICK_DIV    = 16,
  parameter int STABLE_CNT  = 8,
  parameter int REPEAT_DLY  = 64,
  parameter int REPEAT_RATE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int c_DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_CNT_W   = $clog2(STABLE_CNT + 1);
  localparam int c_RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(TICK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(STABLE_CNT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_RPT_W-1:0] c_RPT_DLY    = c_RPT_W'(REPEAT_DLY);
  localparam logic [c_RPT_W-1:0] c_RPT_ONE    = c_RPT_W'(1);
  // REPEAT_RATE is expected not to exceed REPEAT_DLY.
  localparam logic [c_RPT_W-1:0] c_RPT_RELOAD = c_RPT_W'(REPEAT_DLY - REPEAT_RATE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

  // Two-flop synchroniser for the asynchronous pads.
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Shared sample-tick prescaler.
  logic [c_DIV_W-1:0] r_div;
  logic               w_tick;

  assign w_tick = (r_div == c_DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_DIV_W'(1);
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_RPT_W-1:0] r_rpt;
    logic               r_level;
    logic               r_press;
    logic               r_release;
    logic               r_repeat;
    logic               w_s;
    logic [c_RPT_W-1:0] w_rpt_inc;

    assign w_s       = r_sync2[gi];
    assign w_rpt_inc = r_rpt + c_RPT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_rpt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_repeat  <= 1'b0;
        if (w_tick) begin
          case (r_state)
            IDLE: begin
              if (w_s) begin
                if (STABLE_CNT == 1) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
                  r_rpt   <= '0;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
                end else begin
                  r_state <= ARM;
                  r_cnt   <= c_CNT_ONE;
                end
              end
            end
            ARM: begin
              if (!w_s) begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end else if (r_cnt == c_CNT_LAST) begin
                r_state <= HELD;
                r_cnt   <= '0;
                r_rpt   <= '0;
                r_level <= 1'b1;
                r_press <= 1'b1;
              end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
              end
            end
            HELD: begin
              if (!w_s) begin
                if (STABLE_CNT == 1) begin
                  r_state   <= IDLE;
                  r_cnt     <= '0;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
                end else begin
                  r_state <= REL;
                  r_cnt   <= c_CNT_ONE;
                end
              end else if (repeat_en[gi]) begin
                // Reload keeps the counter bounded by REPEAT_DLY.
                if (w_rpt_inc == c_RPT_DLY) begin
                  r_rpt    <= c_RPT_RELOAD;
                  r_repeat <= 1'b1;
                end else begin
                  r_rpt <= w_rpt_inc;
                end
              end
            end
            REL: begin
              if (w_s) begin
                r_state <= HELD;
                r_cnt   <= '0;
              end else if (r_cnt == c_CNT_LAST) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_release <= 1'b1;
              end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
              end
            end
            default: begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
        if (!repeat_en[gi]) begin
          r_rpt <= '0;
        end
      end
    end

    assign btn_level[gi]   = r_level;
    assign btn_press[gi]   = r_press;
    assign btn_release[gi] = r_release;
    assign btn_repeat[gi]  = r_repeat;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_ctrl
// Brief    : Directed vector table plus randomized run against a run-length
//            reference model of the button event controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int RD = 4;
  localparam int RR = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .N_BTN      (N),
    .TICK_DIV   (TD),
    .STABLE_CNT (SC),
    .REPEAT_DLY (RD),
    .REPEAT_RATE(RR)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  // Reference model: a level flips once SC consecutive tick samples disagree
  // with it; repeats fire when the count of held ticks hits RD, RD+RR, ...
  int           m_div;
  logic [N-1:0] m_q1, m_q2, m_level;
  int           m_run [N];
  int           m_held[N];
  logic [N-1:0] e_level, e_press, e_release, e_repeat;

  task automatic model_reset();
    m_div = 0; m_q1 = '0; m_q2 = '0; m_level = '0;
    for (int b = 0; b < N; b++) begin
      m_run[b] = 0;
      m_held[b] = 0;
    end
    e_level = '0; e_press = '0; e_release = '0; e_repeat = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] s;
    bit           tick;
    s    = m_q2;
    tick = (m_div == TD - 1);
    m_div = (m_div + 1) % TD;
    e_press = '0; e_release = '0; e_repeat = '0;
    for (int b = 0; b < N; b++) begin
      if (tick) begin
        if (s[b] != m_level[b]) begin
          m_run[b]++;
          if (m_run[b] == SC) begin
            m_level[b] = s[b];
            m_run[b]   = 0;
            if (s[b]) begin
              e_press[b] = 1'b1;
              m_held[b]  = 0;
            end else begin
              e_release[b] = 1'b1;
            end
          end
        end else begin
          if (m_level[b] && m_run[b] == 0 && repeat_en[b]) begin
            m_held[b]++;
            if (m_held[b] == RD || (m_held[b] > RD && (m_held[b] - RD) % RR == 0))
              e_repeat[b] = 1'b1;
          end
          m_run[b] = 0;
        end
      end
      if (!repeat_en[b]) m_held[b] = 0;
    end
    e_level = m_level;
    m_q2 = m_q1;
    m_q1 = btn_raw;
  endtask

  task automatic check4(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    k++;
    check4("model_level",   btn_level,   e_level);
    check4("model_press",   btn_press,   e_press);
    check4("model_release", btn_release, e_release);
    check4("model_repeat",  btn_repeat,  e_repeat);
  endtask

  // Reset asserted between edges: outputs must clear without waiting for clk.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check4("reset_level",   btn_level,   '0);
    check4("reset_press",   btn_press,   '0);
    check4("reset_release", btn_release, '0);
    check4("reset_repeat",  btn_repeat,  '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  typedef struct {
    int           cyc;
    logic [N-1:0] raw;
    logic [N-1:0] en;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int cyc, input logic [N-1:0] raw, input logic [N-1:0] en,
                     input logic [N-1:0] lvl, input logic [N-1:0] prs,
                     input logic [N-1:0] rel, input logic [N-1:0] rpt);
    vec_t v;
    v.cyc = cyc; v.raw = raw; v.en = en;
    v.lvl = lvl; v.prs = prs; v.rel = rel; v.rpt = rpt;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;

    // cyc 0 entries restart from reset; raw/en are driven after each check.
    // Press on btn0, glitch on btn1, repeats, then bouncing release.
    add( 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(11, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(12, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add(13, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(20, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(24, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(27, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(28, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(29, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(35, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(36, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(44, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(48, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(52, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(56, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(63, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(64, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(65, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Buttons 0 and 3 together, reset while still arming.
    add( 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add( 8, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Restart mid-ARM; simultaneous press, no repeats with repeat_en low.
    add( 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(11, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(12, 4'b1001, 4'b0000, 4'b1001, 4'b1001, 4'b0000, 4'b0000);
    add(13, 4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    add(28, 4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    add(36, 4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    add(40, 4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    // Restart mid-HELD with the pads now idle: no pulses afterwards.
    add( 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(12, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(24, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    foreach (tbl[i]) begin
      if (tbl[i].cyc == 0) do_reset();
      while (k < tbl[i].cyc) step();
      check4("vec_level",   btn_level,   tbl[i].lvl);
      check4("vec_press",   btn_press,   tbl[i].prs);
      check4("vec_release", btn_release, tbl[i].rel);
      check4("vec_repeat",  btn_repeat,  tbl[i].rpt);
      btn_raw   = tbl[i].raw;
      repeat_en = tbl[i].en;
    end

    // Randomized run: fast toggling (glitches) first, then long holds.
    btn_raw = '0;
    repeat_en = '1;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      step();
      if (c == 2000) do_reset();
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, (c < 2000) ? 19 : 149) == 0) btn_raw[b] = ~btn_raw[b];
        if ($urandom_range(0, 199) == 0) repeat_en[b] = ~repeat_en[b];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
